// File: rtl/piano_pkg.sv
// Shared definitions for the piano keyboard front end: player FSM encoding,
// note-index constants and the key-priority helper used by tone selection.
package piano_pkg;

    localparam int MAX_KEYS = 8;
    localparam int NOTE_W   = 3;

    typedef enum logic {
        SILENT  = 1'b0,
        PLAYING = 1'b1
    } play_state_e;

    localparam logic [NOTE_W-1:0] NOTE_C4 = 3'd0;
    localparam logic [NOTE_W-1:0] NOTE_D4 = 3'd1;
    localparam logic [NOTE_W-1:0] NOTE_E4 = 3'd2;
    localparam logic [NOTE_W-1:0] NOTE_F4 = 3'd3;
    localparam logic [NOTE_W-1:0] NOTE_G4 = 3'd4;
    localparam logic [NOTE_W-1:0] NOTE_A4 = 3'd5;
    localparam logic [NOTE_W-1:0] NOTE_B4 = 3'd6;
    localparam logic [NOTE_W-1:0] NOTE_C5 = 3'd7;

    // Lowest-index pressed key wins; an empty vector maps to C4 and is
    // qualified separately by the caller.
    function automatic logic [NOTE_W-1:0] lowest_key(input logic [MAX_KEYS-1:0] keys);
        logic [NOTE_W-1:0] idx;
        casez (keys)
            8'b???????1: idx = NOTE_C4;
            8'b??????10: idx = NOTE_D4;
            8'b?????100: idx = NOTE_E4;
            8'b????1000: idx = NOTE_F4;
            8'b???10000: idx = NOTE_G4;
            8'b??100000: idx = NOTE_A4;
            8'b?1000000: idx = NOTE_B4;
            8'b10000000: idx = NOTE_C5;
            default:     idx = NOTE_C4;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/key_debouncer_if.sv
// Keyboard bus: raw switch levels in, debounced levels and note events out.
interface key_debouncer_if #(
    parameter int N_KEYS = 8
);
    logic [N_KEYS-1:0] SW;
    logic [N_KEYS-1:0] KEY_STABLE;
    logic [2:0]        NOTE;
    logic              NOTE_VALID;
    logic              NOTE_ON;
    logic              NOTE_OFF;

    modport master (
        output SW,
        input  KEY_STABLE, NOTE, NOTE_VALID, NOTE_ON, NOTE_OFF
    );

    modport slave (
        input  SW,
        output KEY_STABLE, NOTE, NOTE_VALID, NOTE_ON, NOTE_OFF
    );
endinterface

// File: rtl/switch_debounce.sv
// One key: 2-flop input synchronizer followed by a stability counter that
// only accepts a new level after DEBOUNCE_CYCLES consecutive differing cycles.
module switch_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic CLK,
    input  logic RESET_N,
    input  logic CORE_RESET_N,
    input  logic SW,
    output logic KEY_STABLE
);

    localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_r;
    logic             sync2_r;
    logic             stable_r;
    logic [CNT_W-1:0] cnt_r;

    // Input synchronizer; its data is asynchronous anyway, so it runs on the
    // raw reset and is already primed when the counters leave reset.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= SW;
            sync2_r <= sync1_r;
        end
    end

    // Stability counter: restart on agreement, accept after a full run of disagreement.
    always_ff @(posedge CLK or negedge CORE_RESET_N) begin
        if (!CORE_RESET_N) begin
            cnt_r    <= CNT_ZERO;
            stable_r <= 1'b0;
        end else if (sync2_r == stable_r) begin
            cnt_r    <= CNT_ZERO;
            stable_r <= stable_r;
        end else if (cnt_r == CNT_LAST) begin
            cnt_r    <= CNT_ZERO;
            stable_r <= sync2_r;
        end else begin
            cnt_r    <= cnt_r + CNT_ONE;
            stable_r <= stable_r;
        end
    end

    assign KEY_STABLE = stable_r;

endmodule

// File: rtl/key_debouncer.sv
// Piano key front end: debounces N_KEYS switches and turns the debounced
// set into note-on / note-off events for the lowest pressed key.
module key_debouncer
    import piano_pkg::*;
#(
    parameter int N_KEYS          = 8,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic             CLK,
    input  logic             RESET_N,
    key_debouncer_if.slave   bus
);

    logic                rst_meta_r;
    logic                core_rst_n_r;
    logic [N_KEYS-1:0]   key_stable_s;
    logic [MAX_KEYS-1:0] keys_ext_s;
    logic                any_key_s;
    logic [NOTE_W-1:0]   sel_note_s;

    play_state_e         state_r;
    logic [NOTE_W-1:0]   note_r;
    logic                note_valid_r;
    logic                note_on_r;
    logic                note_off_r;

    // Reset synchronizer: assert immediately, release two clocks later.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            rst_meta_r   <= 1'b0;
            core_rst_n_r <= 1'b0;
        end else begin
            rst_meta_r   <= 1'b1;
            core_rst_n_r <= rst_meta_r;
        end
    end

    for (genvar k = 0; k < N_KEYS; k++) begin : g_key
        switch_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .CLK         (CLK),
            .RESET_N     (RESET_N),
            .CORE_RESET_N(core_rst_n_r),
            .SW          (bus.SW[k]),
            .KEY_STABLE  (key_stable_s[k])
        );
    end

    // Widen the debounced keys to the priority encoder's fixed width.
    always_comb begin
        keys_ext_s               = {MAX_KEYS{1'b0}};
        keys_ext_s[N_KEYS-1:0]   = key_stable_s;
        any_key_s                = |key_stable_s;
        sel_note_s               = lowest_key(keys_ext_s);
    end

    // Player FSM with registered note outputs and single-cycle event pulses.
    always_ff @(posedge CLK or negedge core_rst_n_r) begin
        if (!core_rst_n_r) begin
            state_r      <= SILENT;
            note_r       <= NOTE_C4;
            note_valid_r <= 1'b0;
            note_on_r    <= 1'b0;
            note_off_r   <= 1'b0;
        end else begin
            note_on_r  <= 1'b0;
            note_off_r <= 1'b0;
            case (state_r)
                SILENT: begin
                    if (any_key_s) begin
                        state_r      <= PLAYING;
                        note_r       <= sel_note_s;
                        note_valid_r <= 1'b1;
                        note_on_r    <= 1'b1;
                    end else begin
                        state_r      <= SILENT;
                    end
                end
                PLAYING: begin
                    if (!any_key_s) begin
                        state_r      <= SILENT;
                        note_valid_r <= 1'b0;
                        note_off_r   <= 1'b1;
                    end else if (sel_note_s != note_r) begin
                        note_r       <= sel_note_s;
                        note_on_r    <= 1'b1;
                    end else begin
                        state_r      <= PLAYING;
                    end
                end
                default: begin
                    state_r      <= SILENT;
                    note_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.KEY_STABLE = key_stable_s;
    assign bus.NOTE       = note_r;
    assign bus.NOTE_VALID = note_valid_r;
    assign bus.NOTE_ON    = note_on_r;
    assign bus.NOTE_OFF   = note_off_r;

endmodule
